// File: rtl/adrv9001_pkg.sv
// Shared definitions for the ADRV9001 RX burst-capture path.
package adrv9001_pkg;
  localparam int ADRV9001_SAMPLE_W = 32;
  localparam int BURST_LEN_W       = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  typedef struct packed {
    logic                         last;
    logic [ADRV9001_SAMPLE_W-1:0] data;
  } fifo_word_t;
endpackage

// File: rtl/adrv9001_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; head entry is always on o_rd_data.
module adrv9001_sync_fifo #(
  parameter int W  = 33,
  parameter int AW = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_flush,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]  r_wp, r_rp;
  logic         w_wr, w_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_wr    = i_wr_en && !o_full && !i_flush;
  assign w_rd    = i_rd_en && !o_empty && !i_flush;
  assign o_rd_data = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/adrv9001_rx_burst.sv
// Triggered burst capture: arm, wait for trigger rising edge, store cfg_len samples,
// re-emit them as a backpressured AXI-Stream burst with tlast on the final beat.
module adrv9001_rx_burst
  import adrv9001_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic                         axis_aclk,
  input  logic                         axis_rstn,
  input  logic [BURST_LEN_W-1:0]       cfg_len,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         trigger,
  input  logic [ADRV9001_SAMPLE_W-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic [ADRV9001_SAMPLE_W-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic                         burst_done,
  output logic [BURST_LEN_W-1:0]       overflow_cnt
);
  logic [1:0]             r_state, w_next;
  logic                   r_trig_d;
  logic [BURST_LEN_W-1:0] r_len, r_wr_cnt, r_ovf;
  logic                   r_done;

  fifo_word_t w_wr_word, w_head;
  logic       w_full, w_empty;
  logic       w_arm_ok, w_rise, w_wr_req, w_wr_en, w_drop, w_hs, w_last_wr, w_last_hs;

  assign w_arm_ok  = (r_state == ST_IDLE) && arm && (cfg_len != '0) && !abort;
  assign w_rise    = trigger && !r_trig_d;
  assign w_wr_req  = (r_state == ST_CAPTURE) && s_axis_tvalid && !abort;
  // Full is the pre-read state, so a same-cycle read never frees room for the write.
  assign w_wr_en   = w_wr_req && !w_full;
  assign w_drop    = w_wr_req && w_full;
  assign w_last_wr = (r_wr_cnt == r_len - 1'b1);
  assign w_hs      = !w_empty && m_axis_tready;
  assign w_last_hs = w_hs && w_head.last;

  assign w_wr_word.last = w_last_wr;
  assign w_wr_word.data = s_axis_tdata;

  adrv9001_sync_fifo #(.W($bits(fifo_word_t)), .AW(FIFO_AW)) u_fifo (
    .i_clk     (axis_aclk),
    .i_rstn    (axis_rstn),
    .i_flush   (abort),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_hs),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge axis_aclk or negedge axis_rstn) begin
    if (!axis_rstn) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_arm_ok) w_next = ST_ARMED;
        ST_ARMED:   if (w_rise) w_next = ST_CAPTURE;
        ST_CAPTURE: if (w_wr_en && w_last_wr) w_next = ST_DRAIN;
        ST_DRAIN:   if (w_last_hs) w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // Data and last are gated so the (unreset) storage never leaks onto an idle bus.
  always_comb begin
    busy          = (r_state != ST_IDLE);
    m_axis_tvalid = !w_empty;
    m_axis_tdata  = w_empty ? '0 : w_head.data;
    m_axis_tlast  = !w_empty && w_head.last;
  end

  always_ff @(posedge axis_aclk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      r_trig_d <= 1'b0;
      r_len    <= '0;
      r_wr_cnt <= '0;
      r_ovf    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_trig_d <= trigger;
      r_done   <= (r_state == ST_DRAIN) && w_last_hs && !abort;
      if (w_arm_ok) begin
        r_len    <= cfg_len;
        r_wr_cnt <= '0;
        r_ovf    <= '0;
      end else begin
        if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
      end
    end
  end

  assign burst_done   = r_done;
  assign overflow_cnt = r_ovf;
endmodule

// File: tb/tb_adrv9001_rx_burst.sv
// Self-checking bench: table-driven basic burst, directed corner cases, and randomized
// bursts checked every cycle against a queue-based reference model.
module tb_adrv9001_rx_burst;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_len;
  logic        arm, abort, trigger, s_axis_tvalid, m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, busy, burst_done;
  logic [15:0] overflow_cnt;

  always #5 clk = ~clk;

  adrv9001_rx_burst #(.FIFO_AW(AW)) dut (
    .axis_aclk(clk), .axis_rstn(rstn), .cfg_len(cfg_len), .arm(arm), .abort(abort),
    .trigger(trigger), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .burst_done(burst_done),
    .overflow_cnt(overflow_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 waiting for trigger, 2 collecting, 3 emptying.
  typedef struct {
    logic        last;
    logic [31:0] data;
  } ent_t;
  ent_t        q[$];
  int          m_mode;
  logic        m_tp, m_done;
  logic [15:0] m_len, m_wcnt, m_ovf;

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_tp = 1'b0; m_done = 1'b0;
    m_len = '0; m_wcnt = '0; m_ovf = '0;
  endtask

  task automatic model_step();
    bit   hs, hl, full;
    ent_t e;
    hs   = (q.size() > 0) && m_axis_tready;
    hl   = hs && q[0].last;
    full = (q.size() == DEPTH);
    m_done = 1'b0;
    if (abort) begin
      m_mode = 0;
      q.delete();
    end else begin
      case (m_mode)
        0: if (arm && cfg_len != 0) begin
             m_mode = 1; m_len = cfg_len; m_wcnt = 0; m_ovf = 0;
           end
        1: if (trigger && !m_tp) m_mode = 2;
        2: if (s_axis_tvalid) begin
             if (!full) begin
               e.last = (m_wcnt == m_len - 16'd1);
               e.data = s_axis_tdata;
               q.push_back(e);
               m_wcnt++;
               if (e.last) m_mode = 3;
             end else if (m_ovf != 16'hFFFF) m_ovf++;
           end
        3: if (hl) begin m_done = 1'b1; m_mode = 0; end
        default: m_mode = 0;
      endcase
      if (hs) void'(q.pop_front());
    end
    m_tp = trigger;
  endtask

  task automatic compare_all();
    check("tvalid", m_axis_tvalid, q.size() > 0);
    check("tdata", m_axis_tdata, (q.size() > 0) ? q[0].data : 32'd0);
    check("tlast", m_axis_tlast, (q.size() > 0) ? q[0].last : 1'b0);
    check("busy", busy, m_mode != 0);
    check("burst_done", burst_done, m_done);
    check("overflow_cnt", overflow_cnt, m_ovf);
  endtask

  int          beats, last_at;
  logic [31:0] beat_data[$];

  task automatic clr_beats();
    beats = 0; last_at = -1; beat_data.delete();
  endtask

  // One clock: record the handshake seen before the edge, advance the model, compare after.
  task automatic cyc();
    @(negedge clk);
    if (m_axis_tvalid && m_axis_tready) begin
      beats++;
      beat_data.push_back(m_axis_tdata);
      if (m_axis_tlast) last_at = beats;
    end
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max && busy; i++) cyc();
    check(name, busy, 1'b0);
    cyc();
  endtask

  task automatic pulse_arm(input logic [15:0] len);
    cfg_len = len; arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  typedef struct {
    logic        arm, trig, sv, rdy;
    logic [15:0] len;
    logic [31:0] d;
    logic        e_v, e_l, e_b, e_done;
    logic [31:0] e_d;
  } vec_t;
  vec_t tv[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cfg_len = '0; arm = 0; abort = 0; trigger = 0;
    s_axis_tvalid = 0; s_axis_tdata = '0; m_axis_tready = 0;
    model_reset();
    clr_beats();

    // Basic 8-sample burst, hand-derived expectations.
    for (int k = 0; k < 12; k++) begin
      tv[k] = '{arm:0, trig:(k >= 1 && k <= 9), sv:(k >= 2 && k <= 9), rdy:1, len:16'd8,
                d:(k >= 2) ? 32'(k - 2) : 32'd0,
                e_v:(k >= 2 && k <= 9), e_l:(k == 9), e_b:(k <= 9), e_done:(k == 10),
                e_d:(k >= 2 && k <= 9) ? 32'(k - 2) : 32'd0};
    end
    tv[0].arm = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_tvalid", m_axis_tvalid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_tdata", m_axis_tdata, 32'd0);
    check("reset_ovf", overflow_cnt, 16'd0);
    rstn = 1'b1;

    for (int k = 0; k < 12; k++) begin
      arm = tv[k].arm; cfg_len = tv[k].len; trigger = tv[k].trig;
      s_axis_tvalid = tv[k].sv; s_axis_tdata = tv[k].d; m_axis_tready = tv[k].rdy;
      cyc();
      check($sformatf("vec%0d_tvalid", k), m_axis_tvalid, tv[k].e_v);
      check($sformatf("vec%0d_tdata", k), m_axis_tdata, tv[k].e_d);
      check($sformatf("vec%0d_tlast", k), m_axis_tlast, tv[k].e_l);
      check($sformatf("vec%0d_busy", k), busy, tv[k].e_b);
      check($sformatf("vec%0d_done", k), burst_done, tv[k].e_done);
    end
    arm = 0; s_axis_tvalid = 0;
    check("basic_ovf", overflow_cnt, 16'd0);

    // Overflow: 30 samples into a 16-deep FIFO with no drain, then release.
    clr_beats();
    pulse_arm(16'd40);
    trigger = 1'b1; m_axis_tready = 1'b0; cyc();
    for (int i = 0; i < 30; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'(100 + i); cyc();
    end
    s_axis_tvalid = 1'b0;
    check("ovf_after_30", overflow_cnt, 16'd14);
    m_axis_tready = 1'b1; cyc();
    for (int i = 0; i < 24; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'(200 + i); cyc();
    end
    s_axis_tvalid = 1'b0;
    wait_idle("ovf_idle", 100);
    check("ovf_beats", beats, 40);
    check("ovf_last_at", last_at, 40);
    check("ovf_final", overflow_cnt, 16'd14);
    check("ovf_beat15", beat_data[15], 32'd115);
    check("ovf_beat16", beat_data[16], 32'd200);

    // Trigger already high at arm: must fall and rise again; earlier samples vanish.
    clr_beats();
    trigger = 1'b1;
    pulse_arm(16'd4);
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'(300 + i); cyc();
    end
    check("pretrig_busy", busy, 1'b1);
    check("pretrig_tvalid", m_axis_tvalid, 1'b0);
    trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = 32'(310 + i); cyc();
    end
    trigger = 1'b1; s_axis_tdata = 32'd320; cyc();
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = 32'(330 + i); cyc();
    end
    s_axis_tvalid = 1'b0;
    wait_idle("pretrig_idle", 50);
    check("pretrig_beats", beats, 4);
    check("pretrig_first", beat_data[0], 32'd330);
    check("pretrig_last_at", last_at, 4);
    check("pretrig_ovf", overflow_cnt, 16'd0);

    // Zero length is ignored; length one gives a single tlast beat.
    pulse_arm(16'd0);
    cyc();
    check("len0_busy", busy, 1'b0);
    clr_beats();
    trigger = 1'b0;
    pulse_arm(16'd1);
    trigger = 1'b1; cyc();
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hABCD; cyc();
    s_axis_tvalid = 1'b0;
    wait_idle("len1_idle", 20);
    check("len1_beats", beats, 1);
    check("len1_last_at", last_at, 1);
    check("len1_data", beat_data[0], 32'hABCD);

    // Abort mid-capture with 5 queued, then a clean burst.
    trigger = 1'b0;
    pulse_arm(16'd20);
    trigger = 1'b1; m_axis_tready = 1'b0; cyc();
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'(400 + i); cyc();
    end
    s_axis_tvalid = 1'b0;
    check("preabort_tvalid", m_axis_tvalid, 1'b1);
    abort = 1'b1; cyc(); abort = 1'b0;
    check("abort_tvalid", m_axis_tvalid, 1'b0);
    check("abort_busy", busy, 1'b0);
    clr_beats();
    m_axis_tready = 1'b1; trigger = 1'b0;
    pulse_arm(16'd6);
    trigger = 1'b1; cyc();
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'(500 + i); cyc();
    end
    s_axis_tvalid = 1'b0;
    wait_idle("post_abort_idle", 30);
    check("post_abort_beats", beats, 6);
    check("post_abort_first", beat_data[0], 32'd500);
    check("post_abort_last_at", last_at, 6);

    // Randomized bursts against the model.
    for (int b = 0; b < 8; b++) begin
      trigger = 1'b0;
      pulse_arm(16'($urandom_range(1, 40)));
      trigger = 1'b1; cyc();
      for (int i = 0; i < 400 && busy; i++) begin
        s_axis_tvalid = ($urandom % 4) != 0;
        s_axis_tdata  = $urandom;
        m_axis_tready = ($urandom % 3) != 0;
        trigger       = $urandom % 2;
        arm           = ($urandom % 8) == 0;
        cfg_len       = 16'($urandom_range(0, 50));
        abort         = (b == 3 && i == 10);
        cyc();
      end
      arm = 0; abort = 0; s_axis_tvalid = 0; m_axis_tready = 1'b1;
      check($sformatf("rand%0d_idle", b), busy, 1'b0);
      cyc();
    end

    // Asynchronous reset while draining.
    trigger = 1'b0;
    pulse_arm(16'd8);
    trigger = 1'b1; m_axis_tready = 1'b0; cyc();
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'(600 + i); cyc();
    end
    s_axis_tvalid = 1'b0;
    check("drain_tvalid", m_axis_tvalid, 1'b1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("arst_tvalid", m_axis_tvalid, 1'b0);
    check("arst_tlast", m_axis_tlast, 1'b0);
    check("arst_tdata", m_axis_tdata, 32'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", burst_done, 1'b0);
    check("arst_ovf", overflow_cnt, 16'd0);
    model_reset();
    trigger = 1'b0; m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
